// File: rtl/cmp_serial_if.sv
// cmp_serial_if: start/done compare handshake with operands and registered results
// Macro: none. The master drives start, is_signed, a and b; the slave returns
// busy, done, greater, less and equal.
interface cmp_serial_if #(parameter int WIDTH = 16);
  logic start;
  logic is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic greater;
  logic less;
  logic equal;
  modport master (output start, is_signed, a, b, input busy, done, greater, less, equal);
  modport slave (input start, is_signed, a, b, output busy, done, greater, less, equal);
endinterface

// File: rtl/cmp_serial.sv
// cmp_serial: multi-cycle MSB-chunk-first magnitude comparator, unsigned or two's complement
// Ports: clk, rst_n (async active-low), bus (cmp_serial_if.slave: start/is_signed/a/b in,
// busy/done/greater/less/equal out).
// Macro CMP_SERIAL_EARLY_EXIT_EN: stop at the first differing chunk instead of scanning all chunks.
module cmp_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input logic clk,
  input logic rst_n,
  cmp_serial_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = $clog2(NCHUNK);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] a_r, b_r;
  logic sgn;
  logic [IW-1:0] idx;
  logic gt_s, lt_s;
  logic [CHUNK-1:0] msk, ca, cb;
  logic c_gt, c_lt, new_gt, new_lt, finish, accept;
  // Operands shift left each RUN cycle, so the chunk under test is always the top one.
  // Flipping the sign bit of the top chunk turns a signed compare into an unsigned one.
  always_comb begin
    accept = bus.start && state != RUN;
    msk = CHUNK'(sgn && idx == IW'(NCHUNK - 1)) << (CHUNK - 1);
    ca = a_r[WIDTH-1 -: CHUNK] ^ msk;
    cb = b_r[WIDTH-1 -: CHUNK] ^ msk;
    c_gt = ca > cb;
    c_lt = ca < cb;
    new_gt = gt_s || (!lt_s && c_gt);
    new_lt = lt_s || (!gt_s && c_lt);
`ifdef CMP_SERIAL_EARLY_EXIT_EN
    finish = idx == '0 || c_gt || c_lt;
`else
    finish = idx == '0;
`endif
    state_d = accept ? RUN : state == RUN ? (finish ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      sgn <= 1'b0;
      idx <= '0;
      gt_s <= 1'b0;
      lt_s <= 1'b0;
      bus.greater <= 1'b0;
      bus.less <= 1'b0;
      bus.equal <= 1'b0;
    end else if (accept) begin
      a_r <= bus.a;
      b_r <= bus.b;
      sgn <= bus.is_signed;
      idx <= IW'(NCHUNK - 1);
      gt_s <= 1'b0;
      lt_s <= 1'b0;
      bus.greater <= 1'b0;
      bus.less <= 1'b0;
      bus.equal <= 1'b0;
    end else if (state == RUN) begin
      a_r <= a_r << CHUNK;
      b_r <= b_r << CHUNK;
      idx <= idx - 1'b1;
      gt_s <= new_gt;
      lt_s <= new_lt;
      if (finish) begin
        bus.greater <= new_gt;
        bus.less <= new_lt;
        bus.equal <= !(new_gt || new_lt);
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_cmp_serial.sv
// tb_cmp_serial: directed vector table plus handshake corner sequences for cmp_serial
module tb_cmp_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nfail = 0;
  cmp_serial_if #(.WIDTH(16)) bus ();
  cmp_serial #(.WIDTH(16), .CHUNK(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic s;
    logic g;
    logic l;
    logic e;
    int lat;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int lat_of(input int early);
`ifdef CMP_SERIAL_EARLY_EXIT_EN
    return early;
`else
    return 8;
`endif
  endfunction
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_accept", int'(bus.busy), 1);
    chk("done_after_accept", int'(bus.done), 0);
  endtask
  task automatic wait_done(input string nm, input int n0, input int lat, input logic g, input logic l, input logic e);
    int n = n0;
    while (!bus.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_busy_in_done"}, int'(bus.busy), 0);
    chk({nm, "_result"}, int'({bus.greater, bus.less, bus.equal}), int'({g, l, e}));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tbl[0] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, lat_of(1)};
    tbl[1] = '{16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    tbl[2] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 8};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, lat_of(1)};
    tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, lat_of(1)};
    tbl[5] = '{16'h0004, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 8};
    tbl[6] = '{16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, lat_of(1)};
    tbl[7] = '{16'h0040, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, lat_of(5)};
    tbl[8] = '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, lat_of(1)};
    #1;
    chk("reset_outputs", int'({bus.busy, bus.done, bus.greater, bus.less, bus.equal}), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].s);
      wait_done($sformatf("vec%0d", i), 0, tbl[i].lat, tbl[i].g, tbl[i].l, tbl[i].e);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("hold_in_idle", int'({bus.done, bus.greater, bus.less, bus.equal}), int'(4'b0100));
    issue(16'h0010, 16'h0001, 1'b0);
    bus.start = 1'b1;
    bus.a = 16'h0000;
    bus.b = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ignored_start_no_done", int'(bus.done), 0);
    wait_done("ignored_start", 1, lat_of(6), 1'b1, 1'b0, 1'b0);
    issue(16'h0001, 16'h0002, 1'b0);
    wait_done("back_to_back", 0, 8, 1'b0, 1'b1, 1'b0);
    issue(16'h00F0, 16'h000F, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({bus.busy, bus.done, bus.greater, bus.less, bus.equal}), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) chk("no_done_in_reset", int'(bus.done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_reset", int'({bus.busy, bus.done}), 0);
    issue(16'h00FF, 16'h00FF, 1'b0);
    wait_done("after_reset", 0, 8, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(bus.done), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
